// File: rtl/stoch_pkg.sv
// Shared stochastic-datapath package: epoch FSM states and default timing constants.
// The WARM state is compiled in only with STOCH_EPOCH_WARMUP_EN.
package stoch_pkg;

    localparam int DEFAULT_CLEAR_CYCLES = 2;
    localparam int DEFAULT_WARMUP       = 8;

    // CLEAR_CYCLES fits 1..15, WARMUP fits 1..255
    localparam int CLR_CNT_W  = 4;
    localparam int WARM_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3
`ifdef STOCH_EPOCH_WARMUP_EN
        ,
        WARM  = 3'd4
`endif
    } epoch_state_e;

endpackage

// File: rtl/stoch_ones_counter.sv
// Counts ones on a datapath bitstream while enabled; synchronous clear wins over enable.
module stoch_ones_counter #(
    parameter int LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [LEN_W-1:0] count
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && bit_in) begin
            count <= count + LEN_W'(1);
        end
    end

endmodule

// File: rtl/stoch_epoch_ctrl.sv
// Epoch sequencer for a stochastic datapath: clear, optional warm-up, counted run, result handshake.
// Build option: define STOCH_EPOCH_WARMUP_EN to add the WARM settling phase.
//
// state | meaning
// IDLE  | waiting for start with non-zero len
// CLEAR | datapath held in reset for CLEAR_CYCLES
// WARM  | datapath running, output discarded for WARMUP cycles (option)
// RUN   | datapath running, ones counted for len cycles
// DONE  | result_valid high until result_ready
module stoch_epoch_ctrl
    import stoch_pkg::*;
#(
    parameter int LEN_W        = 16,
    parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES,
    parameter int WARMUP       = DEFAULT_WARMUP
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             dp_nrst,
    output logic             dp_en,
    input  logic             dp_y,
    output logic [LEN_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > 15 || WARMUP < 1 || WARMUP > 255) begin : g_bad_param
        $error("stoch_epoch_ctrl: CLEAR_CYCLES must be 1..15 and WARMUP 1..255");
    end

    epoch_state_e         state_q, state_d;
    logic [CLR_CNT_W-1:0] clr_cnt_q;
    logic [LEN_W-1:0]     run_cnt_q;
    logic [LEN_W-1:0]     ones_cnt;
    logic [LEN_W-1:0]     result_q;
    logic                 start_acc;
    logic                 count_en;
    logic                 nrst_d, en_d;
    logic                 dp_nrst_q, dp_en_q;
`ifdef STOCH_EPOCH_WARMUP_EN
    logic [WARM_CNT_W-1:0] warm_cnt_q;
`endif

    assign start_acc = (state_q == IDLE) && start && (len != '0);
    assign count_en  = (state_q == RUN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            dp_nrst_q <= 1'b0;
            dp_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dp_nrst_q <= nrst_d;
            dp_en_q   <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_acc) state_d = CLEAR;
            end
            CLEAR: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (clr_cnt_q == CLR_CNT_W'(1)) begin
`ifdef STOCH_EPOCH_WARMUP_EN
                    state_d = WARM;
`else
                    state_d = RUN;
`endif
                end
            end
`ifdef STOCH_EPOCH_WARMUP_EN
            WARM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (warm_cnt_q == WARM_CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
`endif
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (run_cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // abort and result_ready both return to IDLE, so priority is implicit
                if (abort || result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Datapath controls are registered from the next state so they line up with it
        nrst_d = (state_d != CLEAR);
`ifdef STOCH_EPOCH_WARMUP_EN
        en_d   = (state_d == RUN) || (state_d == WARM);
`else
        en_d   = (state_d == RUN);
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_cnt_q  <= '0;
            run_cnt_q  <= '0;
`ifdef STOCH_EPOCH_WARMUP_EN
            warm_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        clr_cnt_q  <= CLR_CNT_W'(CLEAR_CYCLES);
                        run_cnt_q  <= len;
`ifdef STOCH_EPOCH_WARMUP_EN
                        warm_cnt_q <= WARM_CNT_W'(WARMUP);
`endif
                    end
                end
                CLEAR: clr_cnt_q <= clr_cnt_q - CLR_CNT_W'(1);
`ifdef STOCH_EPOCH_WARMUP_EN
                WARM:  warm_cnt_q <= warm_cnt_q - WARM_CNT_W'(1);
`endif
                RUN:   run_cnt_q <= run_cnt_q - LEN_W'(1);
                default: ;
            endcase
        end
    end

    stoch_ones_counter #(
        .LEN_W (LEN_W)
    ) u_ones (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (start_acc),
        .en     (count_en),
        .bit_in (dp_y),
        .count  (ones_cnt)
    );

    // The ones counter is frozen in DONE; snapshot it so result survives the next clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_q <= '0;
        end else if (state_q == DONE) begin
            result_q <= ones_cnt;
        end
    end

    assign result       = (state_q == DONE) ? ones_cnt : result_q;
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign dp_nrst      = dp_nrst_q;
    assign dp_en        = dp_en_q;

endmodule

// File: doc/stoch_epoch_ctrl.md
STOCH_EPOCH_CTRL -- requirements
Module: stoch_epoch_ctrl

Interface
REQ-001 The module SHALL have parameter LEN_W, default 16, width of epoch length and result.
REQ-002 The module SHALL have parameter CLEAR_CYCLES, default 2, cycles datapath is held in reset before an epoch (1..15).
REQ-003 The module SHALL have parameter WARMUP, default 8, discarded settling cycles (used only with the warm-up macro, 1..255).
REQ-004 The module SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-005 The module SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-006 The module SHALL have port start  in  1  request a new epoch.
REQ-007 The module SHALL have port len  in  LEN_W  epoch length in counted cycles, sampled with accepted start.
REQ-008 The module SHALL have port abort  in  1  cancel the current epoch.
REQ-009 The module SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 The module SHALL have port dp_nrst  out  1  active-low synchronous reset to the stochastic datapath (e.g. averager counter).
REQ-011 The module SHALL have port dp_en  out  1  datapath advance enable.
REQ-012 The module SHALL have port dp_y  in  1  datapath output bitstream, combinational from datapath.
REQ-013 The module SHALL have port result  out  LEN_W  count of dp_y ones over the counted epoch.
REQ-014 The module SHALL have port result_valid  out  1  result available.
REQ-015 The module SHALL have port result_ready  in  1  consumer accepts result.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, WARM, RUN, DONE; WARM exists only with the warm-up macro.
REQ-017 In IDLE, start=1 with len!=0 SHALL latch len, zero the ones counter, and enter CLEAR next cycle; start with len==0 SHALL be ignored.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 CLEAR SHALL last exactly CLEAR_CYCLES cycles with dp_nrst=0 and dp_en=0, then enter WARM (macro on) or RUN.
REQ-020 WARM SHALL last exactly WARMUP cycles with dp_nrst=1 and dp_en=1, dp_y not counted, then enter RUN.
REQ-021 RUN SHALL last exactly the latched len cycles with dp_nrst=1 and dp_en=1, adding dp_y to the ones counter each cycle.
REQ-022 On the cycle after the last RUN cycle, the FSM SHALL enter DONE with result equal to the final count and result_valid=1.
REQ-023 The count SHALL never exceed len, so no saturation is required; the cycle counter SHALL be LEN_W bits, counting down to 1.
REQ-024 In DONE, result and result_valid SHALL hold stable until result_ready=1, then return to IDLE next cycle with result_valid=0.
REQ-025 Outside DONE, result_valid SHALL be 0; result SHALL retain its last value.
REQ-026 dp_nrst SHALL be 1 and dp_en SHALL be 0 in IDLE and DONE, so the datapath holds its state.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE next cycle with no result_valid pulse; abort SHALL take priority over result_ready and over state completion.
REQ-028 Latency from accepted start to result_valid SHALL be 1+CLEAR_CYCLES+len cycles, plus WARMUP with the macro.

Reset
REQ-029 RST=1 SHALL asynchronously force IDLE, counters 0, result 0, result_valid 0, dp_en 0, busy 0, dp_nrst 0.
REQ-030 dp_nrst SHALL go to 1 on the first clock edge after RST deasserts; reset mid-epoch SHALL discard the epoch.

Configuration
REQ-031 The macro STOCH_EPOCH_WARMUP_EN SHALL compile in the WARM state, its counter, and the WARMUP use; without it CLEAR goes directly to RUN and WARMUP is unused.

Structure
REQ-032 The state enum and the default CLEAR_CYCLES/WARMUP constants SHALL live in the shared stochastic package stoch_pkg.
REQ-033 A sub-module stoch_ones_counter (enable, clear, bit in, LEN_W count out) SHALL implement the ones accumulation.

Verification
REQ-034 Macro off, LEN_W=16, CLEAR_CYCLES=2, dp_y tied 1, start with len=10 -> dp_nrst low 2 cycles, dp_en high 10 cycles, result_valid on cycle 13 with result=10.
REQ-035 dp_y alternating 1,0 from first RUN cycle, len=7 -> result=4; result_ready held 0 for 5 cycles -> result/result_valid stable throughout.
REQ-036 Macro on, WARMUP=8, dp_y=1 during WARM and 0 during RUN, len=5 -> result=0, result_valid 16 cycles after start.
REQ-037 abort asserted in RUN third cycle, and separately in DONE together with result_ready -> IDLE next cycle, no further result_valid, busy=0.
REQ-038 start with len=0, and start pulsed during RUN -> ignored, no state change, no epoch restarted.
REQ-039 RST pulsed asynchronously mid-RUN between edges -> outputs take reset values immediately; a subsequent start with len=3 completes normally with correct result.
